mack_dtack_gen: RTL and testbench

//  68000 bus-cycle terminator downstream of the address decoder. Consumes the decoder's

---
 rtl/mack_dtack_gen.sv | 160 ++++++++++++++++
 tb/tb_mack_dtack_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mack_dtack_gen.sv
`default_nettype none
// ============================================================================
// Module   : mack_dtack_gen
// Brief    : 68000 bus-cycle terminator. It generates a wait-counted DTACK for
//            ROM and RAM, and passes through a synchronised peripheral DTACK.
//            Optional build macro MACK_BERR_EN adds a BERR watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mack_dtack_gen #(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 0
`ifdef MACK_BERR_EN
  ,
  parameter int unsigned TIMEOUT  = 64
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic as_i,
  input  logic romen_i,
  input  logic ramen_i,
  input  logic mfpen_i,
  input  logic duarten_i,
  input  logic dtack_in_i,
  output logic dtack_o,
  output logic berr_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACK    = 2'd2,
    PERIPH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       s1_q, s2_q;
  logic       dtack_q, dtack_d;
  logic       dtack_raw;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= dtack_in_i;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dtack_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dtack_q <= dtack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dtack_raw = 1'b1;
    case (state_q)
      IDLE: begin
        if (!as_i) begin
          // RAMEN overlaps other selects after boot, so it has lowest priority.
          if (!romen_i) begin
            state_d = COUNT;
            cnt_d   = 4'(ROM_WAIT);
          end else if (!mfpen_i || !duarten_i) begin
            state_d = PERIPH;
          end else if (!ramen_i) begin
            state_d = COUNT;
            cnt_d   = 4'(RAM_WAIT);
          end else begin
            state_d = PERIPH;
          end
        end
      end
      COUNT: begin
        if (as_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (as_i) state_d = IDLE;
      end
      PERIPH: begin
        if (as_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Registering s1 while in PERIPH makes dtack_q track s2 exactly.
    if (state_d == ACK) begin
      dtack_raw = 1'b0;
    end else if (state_d == PERIPH) begin
      dtack_raw = s1_q;
    end
  end

`ifdef MACK_BERR_EN
  logic [7:0] wd_q, wd_d;
  logic       berr_q, berr_d;
  logic       expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q   <= 8'd0;
      berr_q <= 1'b1;
    end else begin
      wd_q   <= wd_d;
      berr_q <= berr_d;
    end
  end

  always_comb begin
    wd_d   = 8'd0;
    expire = 1'b0;
    berr_d = berr_q;
    if (state_q != IDLE) begin
      wd_d = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
    end
    // A DTACK falling on the expiry edge terminates the cycle instead.
    expire = (state_q != IDLE) && (state_d != IDLE) && berr_q && dtack_raw &&
             (wd_q == 8'(TIMEOUT - 1));
    if (state_d == IDLE) begin
      berr_d = 1'b1;
    end else if (expire) begin
      berr_d = 1'b0;
    end
    dtack_d = dtack_raw | ~berr_d;
  end

  assign berr_o = berr_q;
`else
  always_comb begin
    dtack_d = dtack_raw;
  end

  assign berr_o = 1'b1;
`endif

  assign dtack_o = dtack_q;

endmodule
`default_nettype wire

// File: tb/tb_mack_dtack_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mack_dtack_gen
// Brief    : Directed bench for mack_dtack_gen; expected DTACK/BERR transitions
//            are queued with their edge number and matched by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mack_dtack_gen;

  logic clk = 1'b0;
  logic rst, as_n, romen, ramen, mfpen, duarten, dtack_in;
  logic dtack, berr;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int b;

  typedef struct {
    int   cyc;
    logic dtack;
    logic berr;
  } ev_t;
  ev_t exp_q[$];

  logic       mon_en = 1'b0;
  logic [1:0] prev = 2'b11;

  mack_dtack_gen #(.ROM_WAIT(2), .RAM_WAIT(0)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .as_i       (as_n),
    .romen_i    (romen),
    .ramen_i    (ramen),
    .mfpen_i    (mfpen),
    .duarten_i  (duarten),
    .dtack_in_i (dtack_in),
    .dtack_o    (dtack),
    .berr_o     (berr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input int c, input logic d, input logic e);
    ev_t ev;
    ev.cyc   = c;
    ev.dtack = d;
    ev.berr  = e;
    exp_q.push_back(ev);
  endtask

  // Returns at the negedge just before edge e, so inputs set next are sampled at e.
  task automatic to_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en && ({dtack, berr} !== prev)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_change at cycle %0d: got dtack/berr=%b, expected %b held",
                 cyc, {dtack, berr}, prev);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("dtack_berr", {30'd0, dtack, berr}, {30'd0, e.dtack, e.berr});
      end
    end
    prev = {dtack, berr};
  end

  initial begin
    rst = 1'b1; as_n = 1'b1; romen = 1'b1; ramen = 1'b1;
    mfpen = 1'b1; duarten = 1'b1; dtack_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {30'd0, dtack, berr}, 32'd3);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {30'd0, dtack, berr}, 32'd3);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // ROM read; mid-cycle select change must be ignored
    b = cyc + 1;
    expect_ev(b + 3, 1'b0, 1'b1); expect_ev(b + 5, 1'b1, 1'b1);
    as_n = 1'b0; romen = 1'b0;
    to_edge(b + 1); romen = 1'b1; mfpen = 1'b0;
    to_edge(b + 5); as_n = 1'b1; mfpen = 1'b1;
    to_edge(b + 9);

    // RAM + MFP overlap: MFP wins, DTACK from peripheral
    b = cyc + 1;
    expect_ev(b + 5, 1'b0, 1'b1); expect_ev(b + 7, 1'b1, 1'b1);
    as_n = 1'b0; ramen = 1'b0; mfpen = 1'b0;
    to_edge(b + 4); dtack_in = 1'b0;
    to_edge(b + 7); as_n = 1'b1; ramen = 1'b1; mfpen = 1'b1; dtack_in = 1'b1;
    to_edge(b + 11);

    // RAM zero-wait, back-to-back
    b = cyc + 1;
    expect_ev(b + 1, 1'b0, 1'b1); expect_ev(b + 2, 1'b1, 1'b1);
    expect_ev(b + 4, 1'b0, 1'b1); expect_ev(b + 6, 1'b1, 1'b1);
    as_n = 1'b0; ramen = 1'b0;
    to_edge(b + 2); as_n = 1'b1;
    to_edge(b + 3); as_n = 1'b0;
    to_edge(b + 6); as_n = 1'b1; ramen = 1'b1;
    to_edge(b + 10);

    // Aborted ROM cycle, then a fresh ROM cycle gets the full wait
    b = cyc + 1;
    expect_ev(b + 6, 1'b0, 1'b1); expect_ev(b + 7, 1'b1, 1'b1);
    as_n = 1'b0; romen = 1'b0;
    to_edge(b + 2); as_n = 1'b1;
    to_edge(b + 3); as_n = 1'b0;
    to_edge(b + 7); as_n = 1'b1; romen = 1'b1;
    to_edge(b + 11);

    // IACK (no select)
    b = cyc + 1;
    expect_ev(b + 3, 1'b0, 1'b1); expect_ev(b + 5, 1'b1, 1'b1);
    as_n = 1'b0;
    to_edge(b + 2); dtack_in = 1'b0;
    to_edge(b + 5); as_n = 1'b1; dtack_in = 1'b1;
    to_edge(b + 9);

    // ROM beats DUART even with peripheral DTACK already low
    b = cyc + 1;
    expect_ev(b + 3, 1'b0, 1'b1); expect_ev(b + 5, 1'b1, 1'b1);
    as_n = 1'b0; romen = 1'b0; duarten = 1'b0; dtack_in = 1'b0;
    to_edge(b + 5); as_n = 1'b1; romen = 1'b1; duarten = 1'b1; dtack_in = 1'b1;
    to_edge(b + 9);

    // DUART beats RAM: no wait-count DTACK
    b = cyc + 1;
    expect_ev(b + 4, 1'b0, 1'b1); expect_ev(b + 6, 1'b1, 1'b1);
    as_n = 1'b0; duarten = 1'b0; ramen = 1'b0;
    to_edge(b + 3); dtack_in = 1'b0;
    to_edge(b + 6); as_n = 1'b1; duarten = 1'b1; ramen = 1'b1; dtack_in = 1'b1;
    to_edge(b + 10);

    // Unterminated DUART cycle
    b = cyc + 1;
`ifdef MACK_BERR_EN
    expect_ev(b + 64, 1'b1, 1'b0); expect_ev(b + 70, 1'b1, 1'b1);
`endif
    as_n = 1'b0; duarten = 1'b0;
    to_edge(b + 70); as_n = 1'b1; duarten = 1'b1;
    to_edge(b + 74);

    // Peripheral DTACK lands on the would-be expiry edge
    b = cyc + 1;
    expect_ev(b + 64, 1'b0, 1'b1); expect_ev(b + 66, 1'b1, 1'b1);
    as_n = 1'b0; duarten = 1'b0;
    to_edge(b + 63); dtack_in = 1'b0;
    to_edge(b + 66); as_n = 1'b1; duarten = 1'b1; dtack_in = 1'b1;
    to_edge(b + 70);

    // Async reset while DTACK asserted, AS held low through release
    b = cyc + 1;
    expect_ev(b + 3, 1'b0, 1'b1); expect_ev(b + 5, 1'b1, 1'b1);
    expect_ev(b + 9, 1'b0, 1'b1); expect_ev(b + 11, 1'b1, 1'b1);
    as_n = 1'b0; romen = 1'b0;
    to_edge(b + 5);
    #2 rst = 1'b1;
    #1 check("async_reset_immediate", {30'd0, dtack, berr}, 32'd3);
    @(negedge clk); rst = 1'b0;
    to_edge(b + 11); as_n = 1'b1; romen = 1'b1;
    to_edge(b + 15);

    check("leftover_events", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
